mtr_drv: RTL and testbench
==========================

# mtr_drv

Motor drive stage downstream of the heading PID controller. Consumes the signed 11-bit left/right wheel speed commands and produces complementary, dead-time-protected PWM pairs for two H-bridge half-legs. Speed commands are sampled once per PWM period (double-buffered), so duty never changes mid-period. An optional slew limiter bounds the duty step between consecutive periods.

## Interface
- NONOVERLAP, 11'd32: dead-time in clocks inserted before each rising edge of either PWM output of a pair.
- SLEW_STEP, 11'd64: maximum duty change per period when slew limiting is compiled in.
- clk  input  1  system clock.
- rst_n  input  1  reset, asynchronous, active-low.
- lft_spd  input  11  signed left speed command, -1024..+1023; 0 = stopped.
- rght_spd  input  11  signed right speed command, same encoding.
- lftPWM1  output  1  left high-side drive.
- lftPWM2  output  1  left low-side drive.
- rghtPWM1  output  1  right high-side drive.
- rghtPWM2  output  1  right low-side drive.
- period_strt  output  1  one-clock pulse marking the first cycle of each PWM period.

## Operation
- Period counter cnt: 11-bit unsigned, free-running 0..2047, wraps 2047->0; period = 2048 clocks.
- Target duty: tgt = spd + 11'h400 (equivalently spd with MSB inverted); -1024->0, 0->1024, +1023->2047.
- Duty registers duty_l, duty_r (11-bit unsigned) load only in the cycle cnt==2047; the new value governs the period starting at cnt==0. Inputs are ignored at all other cycles.
- Per pair, combinational next-state from cnt, duty:
  - PWM1_nxt = (cnt >= NONOVERLAP) && (cnt < duty).
  - PWM2_nxt = (cnt >= duty + NONOVERLAP), compared in 12 bits (no wrap).
- All four PWM outputs and period_strt are registered; period_strt_nxt = (cnt == 0).
- Boundaries: duty <= NONOVERLAP -> PWM1 never high; duty + NONOVERLAP > 2047 -> PWM2 never high; PWM1 and PWM2 of a pair are never high in the same cycle; between any PWM1 fall and PWM2 rise, and between PWM2 fall (wrap) and PWM1 rise, both are low for exactly NONOVERLAP clocks (when both phases exist).
- Left and right channels share cnt and are fully independent otherwise.

## Timing
- Reset (async assert): cnt=0, duty_l=duty_r=11'h400, all PWM outputs 0, period_strt 0. Reset mid-period aborts the period immediately; outputs go low asynchronously.
- After reset release, first rising edge: cnt advances 0->1 and registered outputs reflect cnt==0 (period_strt=1, all PWM=0 since NONOVERLAP>0).
- Output latency: one clock from cnt/duty to pins.
- Command latency: a speed change is visible at the pins between 2 and 2049 clocks later (load at cnt==2047, effect from next period's output cycle).
- High-time per period: PWM1 = max(0, duty - NONOVERLAP); PWM2 = max(0, 2048 - duty - NONOVERLAP).

## Configuration
- MTR_DRV_SLEW_EN defined: at each cnt==2047 load, duty moves toward tgt by at most SLEW_STEP: if |tgt - duty| <= SLEW_STEP then duty=tgt, else duty = duty ± SLEW_STEP. Arithmetic in 12 bits; result always within 0..2047. Reset value still 11'h400.
- Not defined: duty = tgt directly at each load; no slew state or logic.

## Test plan
- spd=0 both sides, run 3 periods -> each period PWM1 high 992 clocks, PWM2 high 992 clocks, period_strt every 2048 clocks, never PWM1&PWM2.
- lft_spd=+1023, rght_spd=-1024 -> lftPWM1 high 2015, lftPWM2 never; rghtPWM1 never, rghtPWM2 high 2016.
- Change lft_spd 0->+512 at cnt==1000 -> current period unchanged (992/992); next period PWM1 high 1504, PWM2 high 480.
- Sweep spd across -1024..+1023 in steps of 37 -> dead-time >= 32 on every edge, no overlap, high-times match formulas.
- MTR_DRV_SLEW_EN: step lft_spd 0->+1023 -> successive duties 0x440, 0x480, ... reaching 0x7FF on 16th period; without macro, 0x7FF on first period.
- Assert rst_n low at cnt==700 with PWM1 high -> all outputs low immediately; after release, duty=0x400 and cnt restarts at 0.

Source files
------------

// File: rtl/mtr_drv.sv
// Motor drive stage: signed L/R speed commands -> complementary dead-time-protected PWM pairs.
// Latency: pins follow cnt/duty by one clock; command -> pins 2..2049 clocks (loaded at cnt==2047).
// Backpressure: none; inputs are sampled once per 2048-clock period and ignored otherwise.
// Optional build macro MTR_DRV_SLEW_EN: limit duty change per period to SLEW_STEP.
module mtr_drv #(
  parameter logic [10:0] NONOVERLAP = 11'd32
`ifdef MTR_DRV_SLEW_EN
  , parameter logic [10:0] SLEW_STEP = 11'd64
`endif
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] lft_spd,
  input  logic [10:0] rght_spd,
  output logic        lftPWM1,
  output logic        lftPWM2,
  output logic        rghtPWM1,
  output logic        rghtPWM2,
  output logic        period_strt
);

  // Period counter and double-buffered duty registers.
  logic [10:0] cnt_q, cnt_d;
  logic [10:0] duty_l_q, duty_l_d;
  logic [10:0] duty_r_q, duty_r_d;
  logic        load_en;

  // Target duty: offset-binary view of the signed command (MSB inverted).
  logic [10:0] tgt_l, tgt_r;

  // Registered pin drivers.
  logic lft_pwm1_q, lft_pwm1_d;
  logic lft_pwm2_q, lft_pwm2_d;
  logic rght_pwm1_q, rght_pwm1_d;
  logic rght_pwm2_q, rght_pwm2_d;
  logic prd_strt_q, prd_strt_d;

  assign tgt_l   = {~lft_spd[10], lft_spd[9:0]};
  assign tgt_r   = {~rght_spd[10], rght_spd[9:0]};
  assign load_en = (cnt_q == 11'h7FF);
  assign cnt_d   = cnt_q + 11'd1;

  // High-side is on after the dead-time window and until the duty point.
  function automatic logic hi_side(input logic [10:0] cnt, input logic [10:0] duty);
    hi_side = (cnt >= NONOVERLAP) && (cnt < duty);
  endfunction

  // Low-side is on once the dead-time after the duty point has elapsed; 12-bit
  // compare so a duty near full scale suppresses the low side instead of wrapping.
  function automatic logic lo_side(input logic [10:0] cnt, input logic [10:0] duty);
    lo_side = ({1'b0, cnt} >= ({1'b0, duty} + {1'b0, NONOVERLAP}));
  endfunction

`ifdef MTR_DRV_SLEW_EN
  // Move cur toward tgt by at most SLEW_STEP. Comparisons are done in 12 bits;
  // the selected branch guarantees the 11-bit sum/difference cannot wrap.
  function automatic logic [10:0] slew_toward(input logic [10:0] cur, input logic [10:0] tgt);
    logic [11:0] cur_w, tgt_w, stp_w;
    cur_w = {1'b0, cur};
    tgt_w = {1'b0, tgt};
    stp_w = {1'b0, SLEW_STEP};
    slew_toward = tgt;
    if (tgt_w > (cur_w + stp_w)) begin
      slew_toward = cur + SLEW_STEP;
    end else if (cur_w > (tgt_w + stp_w)) begin
      slew_toward = cur - SLEW_STEP;
    end
  endfunction
`endif

  // Duty next-state: only changes in the last cycle of a period.
  always_comb begin
    duty_l_d = duty_l_q;
    duty_r_d = duty_r_q;
    if (load_en) begin
`ifdef MTR_DRV_SLEW_EN
      duty_l_d = slew_toward(duty_l_q, tgt_l);
      duty_r_d = slew_toward(duty_r_q, tgt_r);
`else
      duty_l_d = tgt_l;
      duty_r_d = tgt_r;
`endif
    end
  end

  // Pin next-state from the shared counter and each channel's own duty.
  always_comb begin
    lft_pwm1_d  = hi_side(cnt_q, duty_l_q);
    lft_pwm2_d  = lo_side(cnt_q, duty_l_q);
    rght_pwm1_d = hi_side(cnt_q, duty_r_q);
    rght_pwm2_d = lo_side(cnt_q, duty_r_q);
    prd_strt_d  = (cnt_q == 11'd0);
  end

  // Counter and duty state; reset parks both channels at 50 % (zero speed).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q    <= 11'd0;
      duty_l_q <= 11'h400;
      duty_r_q <= 11'h400;
    end else begin
      cnt_q    <= cnt_d;
      duty_l_q <= duty_l_d;
      duty_r_q <= duty_r_d;
    end
  end

  // Output registers; reset drops every gate drive immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lft_pwm1_q  <= 1'b0;
      lft_pwm2_q  <= 1'b0;
      rght_pwm1_q <= 1'b0;
      rght_pwm2_q <= 1'b0;
      prd_strt_q  <= 1'b0;
    end else begin
      lft_pwm1_q  <= lft_pwm1_d;
      lft_pwm2_q  <= lft_pwm2_d;
      rght_pwm1_q <= rght_pwm1_d;
      rght_pwm2_q <= rght_pwm2_d;
      prd_strt_q  <= prd_strt_d;
    end
  end

  assign lftPWM1     = lft_pwm1_q;
  assign lftPWM2     = lft_pwm2_q;
  assign rghtPWM1    = rght_pwm1_q;
  assign rghtPWM2    = rght_pwm2_q;
  assign period_strt = prd_strt_q;

endmodule

// File: tb/tb_mtr_drv.sv
// Bench for mtr_drv: per-period high-times, edge positions, overlap and period marker
// are checked against a period-level model of the duty rules.
// Clocked at 10 time units; outputs sampled on the falling edge.
module tb_mtr_drv;

  localparam int NOV  = 32;
  localparam int STEP = 64;
`ifdef MTR_DRV_SLEW_EN
  localparam int STEP_PER = 17;
`else
  localparam int STEP_PER = 2;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [10:0] lft_spd = 11'd0;
  logic [10:0] rght_spd = 11'd0;
  logic        lftPWM1, lftPWM2, rghtPWM1, rghtPWM2, period_strt;

  int n_cmp = 0;
  int n_bad = 0;
  int m_duty[2];

  mtr_drv dut (
    .clk(clk), .rst_n(rst_n), .lft_spd(lft_spd), .rght_spd(rght_spd),
    .lftPWM1(lftPWM1), .lftPWM2(lftPWM2), .rghtPWM1(rghtPWM1), .rghtPWM2(rghtPWM2),
    .period_strt(period_strt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic [10:0] to_spd(input int v);
    return v[10:0];
  endfunction

  // Duty for the next period from the command seen at the load point.
  function automatic int next_duty(input int duty, input int spd);
    int tgt;
    tgt = spd + 1024;
`ifdef MTR_DRV_SLEW_EN
    if (tgt > duty + STEP) return duty + STEP;
    if (tgt < duty - STEP) return duty - STEP;
`endif
    return tgt;
  endfunction

  function automatic int max0(input int v);
    return (v > 0) ? v : 0;
  endfunction

  // Observe one full period (pos 0..2047 as seen on the pins). Optionally change the
  // commands right after observing pos chg_pos; the command present after pos 2046 is
  // the one the design loads for the following period.
  task automatic run_period(input string tag, input int chg_pos,
                            input logic [10:0] nl, input logic [10:0] nr);
    int hi1[2], hi2[2], f1[2], l1[2], f2[2], l2[2], ovl[2], cmd[2];
    int ps_cnt, ps_pos, d, e1, e2;
    logic p1[2], p2[2];
    for (int c = 0; c < 2; c++) begin
      hi1[c] = 0; hi2[c] = 0; f1[c] = -1; l1[c] = -1; f2[c] = -1; l2[c] = -1;
      ovl[c] = 0; cmd[c] = 0;
    end
    ps_cnt = 0;
    ps_pos = -1;
    for (int pos = 0; pos < 2048; pos++) begin
      @(negedge clk);
      p1[0] = lftPWM1;  p2[0] = lftPWM2;
      p1[1] = rghtPWM1; p2[1] = rghtPWM2;
      for (int c = 0; c < 2; c++) begin
        if (p1[c] === 1'b1) begin hi1[c]++; if (f1[c] < 0) f1[c] = pos; l1[c] = pos; end
        if (p2[c] === 1'b1) begin hi2[c]++; if (f2[c] < 0) f2[c] = pos; l2[c] = pos; end
        if (p1[c] === 1'b1 && p2[c] === 1'b1) ovl[c]++;
      end
      if (period_strt === 1'b1) begin ps_cnt++; ps_pos = pos; end
      if (pos == chg_pos) begin lft_spd = nl; rght_spd = nr; end
      if (pos == 2046) begin cmd[0] = $signed(lft_spd); cmd[1] = $signed(rght_spd); end
    end
    for (int c = 0; c < 2; c++) begin
      string ch;
      ch = (c == 0) ? "L" : "R";
      d  = m_duty[c];
      e1 = max0(d - NOV);
      e2 = max0(2048 - d - NOV);
      chk($sformatf("%s %s hi1", tag, ch), hi1[c], e1);
      chk($sformatf("%s %s hi2", tag, ch), hi2[c], e2);
      if (e1 > 0) begin
        chk($sformatf("%s %s pwm1 rise", tag, ch), f1[c], NOV);
        chk($sformatf("%s %s pwm1 fall", tag, ch), l1[c], d - 1);
      end
      if (e2 > 0) begin
        chk($sformatf("%s %s pwm2 rise", tag, ch), f2[c], d + NOV);
        chk($sformatf("%s %s pwm2 fall", tag, ch), l2[c], 2047);
      end
      chk($sformatf("%s %s overlap", tag, ch), ovl[c], 0);
      m_duty[c] = next_duty(m_duty[c], cmd[c]);
    end
    chk($sformatf("%s period_strt count", tag), ps_cnt, 1);
    chk($sformatf("%s period_strt pos", tag), ps_pos, 0);
  endtask

  initial begin
    int v_l, v_r, v_p, exp_hi;

    // Reset state while held.
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst lftPWM1", lftPWM1, 0);
    chk("rst lftPWM2", lftPWM2, 0);
    chk("rst rghtPWM1", rghtPWM1, 0);
    chk("rst rghtPWM2", rghtPWM2, 0);
    chk("rst period_strt", period_strt, 0);
    rst_n = 1'b1;
    m_duty[0] = 1024;
    m_duty[1] = 1024;

    // Zero speed: 992/992 each period.
    for (int k = 0; k < 3; k++) run_period($sformatf("zero%0d", k), -1, 11'd0, 11'd0);

    // Mid-period change does not affect the current period.
    run_period("mid0", 1000, to_spd(512), 11'd0);
    run_period("mid1", -1, 11'd0, 11'd0);

    // Asynchronous reset mid-period while the left high side is on.
    for (int pos = 0; pos <= 700; pos++) @(negedge clk);
    exp_hi = (700 >= NOV && 700 < m_duty[0]) ? 1 : 0;
    chk("pre-rst lftPWM1", lftPWM1, exp_hi);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async lftPWM1", lftPWM1, 0);
    chk("async lftPWM2", lftPWM2, 0);
    chk("async rghtPWM1", rghtPWM1, 0);
    chk("async rghtPWM2", rghtPWM2, 0);
    chk("async period_strt", period_strt, 0);
    lft_spd = to_spd(500);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    m_duty[0] = 1024;
    m_duty[1] = 1024;

    // Full-scale step: left +1023, right -1024 (slewed when enabled).
    run_period("step0", 0, to_spd(1023), to_spd(-1024));
    for (int k = 1; k < STEP_PER; k++) run_period($sformatf("step%0d", k), -1, 11'd0, 11'd0);

    // A change after the load cycle must wait a whole extra period.
    run_period("late", 2047, to_spd(32 - 1024), to_spd(2016 - 1024));
    run_period("edge0", 0, to_spd(32 - 1024), to_spd(2016 - 1024));
    run_period("edge1", -1, 11'd0, 11'd0);

    // Randomised sweep over the 37-step grid on the left, arbitrary on the right.
    for (int k = 0; k < 12; k++) begin
      v_l = -1024 + 37 * $urandom_range(0, 55);
      v_r = $urandom_range(0, 2047) - 1024;
      v_p = $urandom_range(0, 2047);
      run_period($sformatf("sweep%0d", k), v_p, to_spd(v_l), to_spd(v_r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
